sm_trace_buffer: RTL and testbench
==================================

// Module: sm_trace_buffer
// PURPOSE
// - Synthesizable instruction-trace capture for sm_top; the on-chip successor to the simulation printout and timeout.
// - Each enabled CPU cycle logs {cycle, pc, instr, regData} into a DEPTH-entry buffer, drained through a registered read port.
// - Ring or stop-when-full mode; sticky overflow flag; watchdog freezes capture after TIMEOUT cycles.
// PARAMETERS
// - DEPTH    16   entries, power of two, >= 2
// - CYC_W    16   cycle-counter width
// - DATA_W   32   width of pc, instr and regData fields
// - TIMEOUT  120  enabled cycles before watchdog fires; 0 disables the watchdog
// PORTS
// - clk        in   1             CPU clock (sm_top cpuClk)
// - rst_n      in   1             asynchronous active-low reset
// - clr        in   1             synchronous clear: pointers, count, cycle, flags
// - trace_en   in   1             capture this cycle
// - mode       in   1             0 = ring (overwrite oldest), 1 = stop when full
// - pc         in   DATA_W        sm_cpu.pc
// - instr      in   DATA_W        sm_cpu.instr
// - regData    in   DATA_W        watched register value (sm_top.regData)
// - rd_req     in   1             pop request
// - rd_valid   out  1             rd_* fields valid this cycle
// - rd_cycle   out  CYC_W         popped cycle stamp
// - rd_pc      out  DATA_W        popped pc
// - rd_instr   out  DATA_W        popped instr
// - rd_data    out  DATA_W        popped regData
// - count      out  log2(DEPTH)+1 occupied entries
// - empty      out  1             count == 0
// - full       out  1             count == DEPTH
// - overflow   out  1             sticky: an entry was lost or dropped
// - timeout    out  1             sticky: watchdog fired
// BEHAVIOUR
// - Reset and clr: all outputs 0, empty = 1, wr_ptr = rd_ptr = 0. clr wins over every other event in the same cycle.
// - Cycle counter: +1 each cycle with trace_en && !timeout; saturates at all-ones. Stamp is the pre-increment value, so the first capture = 0.
// - Write: trace_en && !timeout writes at wr_ptr, wr_ptr++. Pointers wrap modulo DEPTH.
// - Read: rd_req && !empty reads at rd_ptr, rd_ptr++. Data and rd_valid are registered: 1-cycle latency, rd_valid high for exactly 1 cycle.
//   - rd_req while empty is ignored; rd_valid = 0 next cycle.
// - Full, write, no read:
//   - ring: overwrite oldest, advance wr_ptr and rd_ptr, count stays DEPTH, set overflow.
//   - stop: drop the write, pointers unchanged, set overflow; the cycle counter still advances.
// - Full, write and read in the same cycle: pop the oldest, push the new entry, count = DEPTH, no overflow, either mode.
// - Empty, write and read in the same cycle: the read is ignored (no bypass), the write lands, count = 1.
// - Watchdog: when TIMEOUT != 0 and the cycle counter reaches TIMEOUT on an enabled cycle:
//   - timeout = 1 (sticky until reset or clr);
//   - no further writes, and the counter holds;
//   - reads remain functional, so the buffer can be drained after a hang.
// - mode is sampled every cycle; changing it with the buffer full only affects later writes.
// - Async reset mid-read: rd_valid drops immediately; the buffer contents are undefined but unreachable (count = 0).
// STRUCTURE
// - sm_trace.vh: `define field offsets, entry width (CYC_W + 3*DATA_W), and SM_TRACE_RING / SM_TRACE_STOP mode constants.
// - Sub-module sm_trace_ram: simple dual-port memory, DEPTH x entry, synchronous write, registered read, no reset on the array.
// - Top level: pointer/count logic, cycle counter, watchdog, flags.
// TESTING
// - Reset, trace_en = 1 for 5 cycles with pc = 0,4,8,12,16, then 5 pops
//   -> rd_cycle 0..4 and rd_pc 0,4,8,12,16 in order; empty = 1 afterwards.
// - DEPTH = 16, mode = 0, 20 captures, no reads
//   -> count = 16, overflow = 1, first pop has rd_cycle = 4.
// - DEPTH = 16, mode = 1, 20 captures
//   -> count = 16, overflow = 1, pops return rd_cycle 0..15.
// - Full buffer, trace_en and rd_req both high for 3 cycles
//   -> count stays 16, overflow stays 0, pops return cycles 0, 1, 2.
// - TIMEOUT = 120, trace_en held high for 200 cycles, mode = 0
//   -> timeout = 1 from the cycle after stamp 119; newest drained entry has rd_cycle = 119; clr then resets timeout to 0.
// - rd_req on empty; rst_n pulsed low mid-drain
//   -> rd_valid = 0 both times; after reset count = 0, empty = 1, flags 0.

Source files
------------

// File: rtl/sm_trace_buffer_pkg.sv
// Shared types and entry-layout helpers for the instruction-trace buffer.
package sm_trace_buffer_pkg;

    // Capture policy when the buffer is full.
    typedef enum logic {
        MODE_RING = 1'b0,
        MODE_STOP = 1'b1
    } trace_mode_e;

    // Entry layout, LSB first: regData, instr, pc, cycle stamp.
    function automatic int unsigned entry_width(input int unsigned cyc_w, input int unsigned data_w);
        return cyc_w + 32'd3 * data_w;
    endfunction

    function automatic int unsigned off_data(input int unsigned data_w);
        return data_w - data_w;
    endfunction

    function automatic int unsigned off_instr(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned off_pc(input int unsigned data_w);
        return 32'd2 * data_w;
    endfunction

    function automatic int unsigned off_cycle(input int unsigned data_w);
        return 32'd3 * data_w;
    endfunction

endpackage

// File: rtl/sm_trace_buffer_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
// The array itself is never reset; only the read register is.
module sm_trace_buffer_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 80
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port: store one entry per enabled cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port: registered, read-before-write when addresses collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sm_trace_buffer.sv
// Instruction-trace capture buffer: pointer/count bookkeeping, cycle stamp,
// ring/stop overflow policy and a watchdog that freezes capture after a hang.
module sm_trace_buffer
    import sm_trace_buffer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CYC_W   = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 120
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       trace_en,
    input  logic                       mode,
    input  logic [DATA_W-1:0]          pc,
    input  logic [DATA_W-1:0]          instr,
    input  logic [DATA_W-1:0]          regData,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [CYC_W-1:0]           rd_cycle,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_instr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       timeout
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = entry_width(CYC_W, DATA_W);
    localparam int O_DATA = off_data(DATA_W);
    localparam int O_INS  = off_instr(DATA_W);
    localparam int O_PC   = off_pc(DATA_W);
    localparam int O_CYC  = off_cycle(DATA_W);

    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
    logic [CNT_W-1:0] count_r, count_nx_s;
    logic [CYC_W-1:0] cycle_r, cycle_nx_s;
    logic             empty_r, full_r, overflow_r, timeout_r, rd_valid_r;
    logic             wr_fire_s, rd_fire_s, push_s, rd_adv_s, ovf_set_s, to_set_s;
    logic [ENT_W-1:0] ram_wdata_s, ram_rdata_s;

    // Next-state: decide whether the entry lands, which pointers move, and flag events.
    always_comb begin
        wr_fire_s = trace_en & ~timeout_r;
        rd_fire_s = rd_req & ~empty_r;
        push_s    = 1'b0;
        rd_adv_s  = rd_fire_s;
        ovf_set_s = 1'b0;
        if (wr_fire_s) begin
            if (!full_r || rd_fire_s) begin
                push_s = 1'b1;
            end else if (trace_mode_e'(mode) == MODE_STOP) begin
                ovf_set_s = 1'b1;
            end else begin
                // Ring overwrite: the oldest entry is discarded in place.
                push_s    = 1'b1;
                rd_adv_s  = 1'b1;
                ovf_set_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end

        wr_ptr_nx_s = push_s   ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
        rd_ptr_nx_s = rd_adv_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;

        if (push_s && !rd_adv_s) begin
            count_nx_s = count_r + CNT_W'(1);
        end else if (!push_s && rd_fire_s) begin
            count_nx_s = count_r - CNT_W'(1);
        end else begin
            count_nx_s = count_r;
        end

        // Dropped stop-mode writes still advance the stamp; it saturates at all-ones.
        if (wr_fire_s && (cycle_r != {CYC_W{1'b1}})) begin
            cycle_nx_s = cycle_r + CYC_W'(1);
        end else begin
            cycle_nx_s = cycle_r;
        end

        to_set_s = (TIMEOUT != 32'sd0) && wr_fire_s && (cycle_nx_s == CYC_W'(TIMEOUT));
    end

    // State registers; clr has priority over every same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            cycle_r    <= {CYC_W{1'b0}};
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
            rd_valid_r <= 1'b0;
        end else if (clr) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            cycle_r    <= {CYC_W{1'b0}};
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nx_s;
            rd_ptr_r   <= rd_ptr_nx_s;
            count_r    <= count_nx_s;
            empty_r    <= (count_nx_s == {CNT_W{1'b0}});
            full_r     <= (count_nx_s == CNT_W'(DEPTH));
            cycle_r    <= cycle_nx_s;
            overflow_r <= overflow_r | ovf_set_s;
            timeout_r  <= timeout_r | to_set_s;
            rd_valid_r <= rd_fire_s;
        end
    end

    assign ram_wdata_s = {cycle_r, pc, instr, regData};

    sm_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .we    (push_s & ~clr),
        .waddr (wr_ptr_r),
        .wdata (ram_wdata_s),
        .re    (rd_fire_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    assign rd_valid = rd_valid_r;
    assign rd_cycle = ram_rdata_s[O_CYC  +: CYC_W];
    assign rd_pc    = ram_rdata_s[O_PC   +: DATA_W];
    assign rd_instr = ram_rdata_s[O_INS  +: DATA_W];
    assign rd_data  = ram_rdata_s[O_DATA +: DATA_W];
    assign count    = count_r;
    assign empty    = empty_r;
    assign full     = full_r;
    assign overflow = overflow_r;
    assign timeout  = timeout_r;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Self-checking bench for sm_trace_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_sm_trace_buffer;

    localparam int DEPTH   = 16;
    localparam int CYC_W   = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 120;

    typedef struct packed {
        logic [15:0] cyc;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] dat;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, clr, trace_en, mode, rd_req;
    logic [31:0] pc, instr, reg_data;
    logic        rd_valid, empty, full, overflow, timeout;
    logic [15:0] rd_cycle;
    logic [31:0] rd_pc, rd_instr, rd_data;
    logic [4:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    ent_t        q[$];
    ent_t        exp_ent;
    logic        exp_valid;
    int          m_cyc;
    logic        m_ovf, m_to;
    logic [15:0] obs_cyc;

    sm_trace_buffer #(
        .DEPTH(DEPTH), .CYC_W(CYC_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .trace_en(trace_en), .mode(mode),
        .pc(pc), .instr(instr), .regData(reg_data), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_data(rd_data), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cyc     = 0;
        m_ovf     = 1'b0;
        m_to      = 1'b0;
        exp_valid = 1'b0;
    endtask

    // One clock of the reference: read the oldest, then apply the capture rules.
    task automatic model_step();
        int   sz0;
        logic did_rd;
        ent_t e;
        exp_valid = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            sz0    = q.size();
            did_rd = rd_req && (sz0 != 0);
            if (did_rd) begin
                exp_ent   = q.pop_front();
                exp_valid = 1'b1;
            end
            if (trace_en && !m_to) begin
                e = '{cyc: 16'(m_cyc), pc: pc, ins: instr, dat: reg_data};
                if (sz0 == DEPTH && !did_rd) begin
                    m_ovf = 1'b1;
                    if (mode == 1'b0) begin
                        void'(q.pop_front());
                        q.push_back(e);
                    end
                end else begin
                    q.push_back(e);
                end
                if (m_cyc != 65535) m_cyc++;
                if (m_cyc == TIMEOUT) m_to = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("rd_cycle", 64'(rd_cycle), 64'(exp_ent.cyc));
            chk("rd_pc",    64'(rd_pc),    64'(exp_ent.pc));
            chk("rd_instr", 64'(rd_instr), 64'(exp_ent.ins));
            chk("rd_data",  64'(rd_data),  64'(exp_ent.dat));
            obs_cyc = rd_cycle;
        end
        chk("count",    64'(count),    64'(q.size()));
        chk("empty",    64'(empty),    64'(q.size() == 0));
        chk("full",     64'(full),     64'(q.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("timeout",  64'(timeout),  64'(m_to));
    endtask

    task automatic cyc(input logic te, input logic req, input logic md, input logic cl,
                       input logic [31:0] pcv);
        trace_en = te;
        rd_req   = req;
        mode     = md;
        clr      = cl;
        pc       = pcv;
        instr    = $urandom;
        reg_data = $urandom;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; trace_en = 1'b0; mode = 1'b0; rd_req = 1'b0;
        pc = 32'd0; instr = 32'd0; reg_data = 32'd0; obs_cyc = 16'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_rd_cycle", 64'(rd_cycle), 64'd0);
        chk("reset_rd_pc",    64'(rd_pc),    64'd0);
        chk("reset_rd_instr", 64'(rd_instr), 64'd0);
        chk("reset_rd_data",  64'(rd_data),  64'd0);
        rst_n = 1'b1;

        // Five captures then five pops in order
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'(i * 4));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            chk("p1_cycle", 64'(rd_cycle), 64'(i));
            chk("p1_pc",    64'(rd_pc),    64'(i * 4));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("p1_empty", 64'(empty), 64'd1);

        // Ring mode, 20 captures, no reads
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
        chk("ring_count",    64'(count),    64'd16);
        chk("ring_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            chk("ring_pop_cycle", 64'(rd_cycle), 64'(i + 4));
        end

        // Stop mode, 20 captures
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        chk("stop_count",    64'(count),    64'd16);
        chk("stop_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            chk("stop_pop_cycle", 64'(rd_cycle), 64'(i));
        end

        // Full buffer with simultaneous push and pop
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, $urandom);
            chk("full_rw_cycle",    64'(rd_cycle), 64'(i));
            chk("full_rw_count",    64'(count),    64'd16);
            chk("full_rw_overflow", 64'(overflow), 64'd0);
        end

        // Empty buffer: simultaneous push and pop lands the push only
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h40);
        chk("empty_rw_valid", 64'(rd_valid), 64'd0);
        chk("empty_rw_count", 64'(count),    64'd1);

        // Watchdog
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
        chk("wd_timeout", 64'(timeout), 64'd1);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("wd_newest_cycle", 64'(obs_cyc), 64'd119);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        chk("wd_clr_timeout", 64'(timeout), 64'd0);

        // Read on empty, then async reset mid-drain
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("empty_read_valid", 64'(rd_valid), 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_valid",    64'(rd_valid), 64'd0);
        chk("rst_mid_count",    64'(count),    64'd0);
        chk("rst_mid_empty",    64'(empty),    64'd1);
        chk("rst_mid_overflow", 64'(overflow), 64'd0);
        chk("rst_mid_timeout",  64'(timeout),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
